hazard_ctrl: RTL

Pipeline hazard controller for the 5-stage MIPS core, sitting beside the ID stage and consuming the decoder's opcode/funct/rs/rt fields. It shadows destination-register information for EX, MEM and WB. From that it generates PC/IF-ID stall, IF/ID and ID/EX flush, and EX-stage operand forwarding selects. It also sequences the multi-cycle HI/LO multiply/divide unit, including a start pulse and a busy interlock.

---
 rtl/pipe_ctrl_pkg.sv | 46 ++++
 rtl/muldiv_tracker.sv | 63 ++++++
 rtl/hazard_ctrl.sv | 101 ++++++++++
 3 files changed

// File: rtl/pipe_ctrl_pkg.sv
// Shared decode constants, forwarding encodings and mul/div state type
// for the pipeline hazard controller.
package pipe_ctrl_pkg;

  // Opcode field values
  localparam logic [5:0] SPECIAL = 6'b000000;
  localparam logic [5:0] J       = 6'b000010;
  localparam logic [5:0] JAL     = 6'b000011;

  // Funct field values under SPECIAL
  localparam logic [5:0] JR      = 6'b001000;
  localparam logic [5:0] MFHI    = 6'b010000;
  localparam logic [5:0] MFLO    = 6'b010010;
  localparam logic [5:0] MULT    = 6'b011000;
  localparam logic [5:0] MULTU   = 6'b011001;
  localparam logic [5:0] DIV     = 6'b011010;
  localparam logic [5:0] DIVU    = 6'b011011;

  // EX operand source selects
  localparam logic [1:0] FWD_RF  = 2'b00;
  localparam logic [1:0] FWD_MEM = 2'b01;
  localparam logic [1:0] FWD_WB  = 2'b10;

  typedef enum logic {IDLE, BUSY} md_state_t;

  // Instruction that launches the mul/div unit
  function automatic logic is_muldiv(input logic [5:0] op, input logic [5:0] fn);
    return (op == SPECIAL) && (fn == MULT || fn == MULTU || fn == DIV || fn == DIVU);
  endfunction

  // Division variants take the longer latency
  function automatic logic is_div(input logic [5:0] op, input logic [5:0] fn);
    return (op == SPECIAL) && (fn == DIV || fn == DIVU);
  endfunction

  // Any instruction that touches HI/LO and must wait for the unit
  function automatic logic is_hilo(input logic [5:0] op, input logic [5:0] fn);
    return is_muldiv(op, fn) || ((op == SPECIAL) && (fn == MFHI || fn == MFLO));
  endfunction

  // Unconditional control transfer resolved in ID
  function automatic logic is_jump(input logic [5:0] op, input logic [5:0] fn);
    return (op == J) || (op == JAL) || ((op == SPECIAL) && (fn == JR));
  endfunction

endpackage

// File: rtl/muldiv_tracker.sv
// Occupancy tracker for the multi-cycle HI/LO unit: start pulse on issue,
// then busy for the latency of the issued operation.
module muldiv_tracker
  import pipe_ctrl_pkg::*;
#(
  parameter int MULT_LAT = 4,
  parameter int DIV_LAT  = 8
) (
  input  logic clk,
  input  logic rst,
  input  logic issue,
  input  logic issue_div,
  output logic hilo_start,
  output logic muldiv_busy
);

  localparam int MAX_LAT = (MULT_LAT > DIV_LAT) ? MULT_LAT : DIV_LAT;
  localparam int CNT_W   = $clog2(MAX_LAT + 1);

  md_state_t        state, state_nxt;
  logic [CNT_W-1:0] cnt, cnt_nxt;

  // State and remaining-cycle counter
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      cnt   <= '0;
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
    end
  end

  // Next state, counter reload/decrement and start pulse
  always_comb begin
    state_nxt  = state;
    cnt_nxt    = cnt;
    hilo_start = 1'b0;
    case (state)
      IDLE: begin
        if (issue) begin
          hilo_start = 1'b1;
          state_nxt  = BUSY;
          cnt_nxt    = issue_div ? CNT_W'(DIV_LAT) : CNT_W'(MULT_LAT);
        end
      end
      BUSY: begin
        cnt_nxt = cnt - 1'b1;
        if (cnt == CNT_W'(1)) begin
          state_nxt = IDLE;
          cnt_nxt   = '0;
        end
      end
      default: begin
        state_nxt = IDLE;
        cnt_nxt   = '0;
      end
    endcase
  end

  assign muldiv_busy = (state == BUSY);

endmodule

// File: rtl/hazard_ctrl.sv
// Hazard controller beside ID: shadows EX/MEM/WB destinations to produce
// stall, flush and forwarding selects, and sequences the mul/div unit.
module hazard_ctrl
  import pipe_ctrl_pkg::*;
#(
  parameter int MULT_LAT = 4,
  parameter int DIV_LAT  = 8
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       id_valid,
  input  logic [5:0] id_opcode,
  input  logic [5:0] id_funct,
  input  logic [4:0] id_rs,
  input  logic [4:0] id_rt,
  input  logic       id_uses_rt,
  input  logic [4:0] id_dst,
  input  logic       id_regwrite,
  input  logic       id_memread,
  input  logic       ex_branch_taken,
  output logic       stall,
  output logic       flush_id,
  output logic       flush_ex,
  output logic [1:0] fwd_a,
  output logic [1:0] fwd_b,
  output logic       hilo_start,
  output logic       muldiv_busy
);

  logic [4:0] ex_rs, ex_rt, ex_dst, mem_dst, wb_dst;
  logic       ex_rw, ex_ld, mem_rw, wb_rw;
  logic       md_busy, md_start, load_use, md_stall, issue;

  // Later stage wins only if the earlier one has no matching writer; $0 never forwards
  function automatic logic [1:0] fwd_sel(input logic [4:0] src,
                                         input logic m_rw, input logic [4:0] m_dst,
                                         input logic w_rw, input logic [4:0] w_dst);
    if (m_rw && m_dst != 5'd0 && m_dst == src)      return FWD_MEM;
    else if (w_rw && w_dst != 5'd0 && w_dst == src) return FWD_WB;
    else                                            return FWD_RF;
  endfunction

  // Hazard detection; reset forces every output low
  always_comb begin
    load_use = id_valid && ex_ld && (ex_dst != 5'd0) &&
               ((ex_dst == id_rs) || (id_uses_rt && ex_dst == id_rt));
    md_stall = md_busy && id_valid && is_hilo(id_opcode, id_funct);
    stall    = !rst && !ex_branch_taken && (load_use || md_stall);
    flush_ex = !rst && (ex_branch_taken || stall);
    flush_id = !rst && (ex_branch_taken ||
               (id_valid && is_jump(id_opcode, id_funct) && !stall));
    issue    = !rst && id_valid && is_muldiv(id_opcode, id_funct) &&
               !stall && !ex_branch_taken;
    fwd_a    = rst ? FWD_RF : fwd_sel(ex_rs, mem_rw, mem_dst, wb_rw, wb_dst);
    fwd_b    = rst ? FWD_RF : fwd_sel(ex_rt, mem_rw, mem_dst, wb_rw, wb_dst);
  end

  // ID -> EX -> MEM -> WB shadow of register-write information
  always_ff @(posedge clk) begin
    if (rst || flush_ex) begin
      ex_rs  <= '0;
      ex_rt  <= '0;
      ex_dst <= '0;
      ex_rw  <= 1'b0;
      ex_ld  <= 1'b0;
    end else begin
      ex_rs  <= id_rs;
      ex_rt  <= id_rt;
      ex_dst <= id_dst;
      ex_rw  <= id_regwrite;
      ex_ld  <= id_memread;
    end
    if (rst) begin
      mem_dst <= '0;
      mem_rw  <= 1'b0;
      wb_dst  <= '0;
      wb_rw   <= 1'b0;
    end else begin
      mem_dst <= ex_dst;
      mem_rw  <= ex_rw;
      wb_dst  <= mem_dst;
      wb_rw   <= mem_rw;
    end
  end

  muldiv_tracker #(
    .MULT_LAT (MULT_LAT),
    .DIV_LAT  (DIV_LAT)
  ) u_muldiv (
    .clk         (clk),
    .rst         (rst),
    .issue       (issue),
    .issue_div   (is_div(id_opcode, id_funct)),
    .hilo_start  (md_start),
    .muldiv_busy (md_busy)
  );

  assign hilo_start  = md_start && !rst;
  assign muldiv_busy = md_busy && !rst;

endmodule
